mcp_phase_seq: RTL and testbench
================================

// Module: mcp_phase_seq
// PURPOSE
//  Four-phase clock sequencer for the MCP-1600 chip set (data chip, control chip, MICROMs).
//  Generates non-overlapping phases C1..C4 from one master clock.
//  Stretches the microcycle on a wait request, and starts/stops microcycles on a run/halt input.
//  Sits at the core top, between the system clock and the C1..C4/WI pins of the chip models.
// PARAMETERS
//  PH_WIDTH    2    master clocks each phase is high (legal range 1..15)
//  GAP_WIDTH   1    master clocks all phases are low after each phase (0..15; 0 removes the gap)
//  TMO_CYCLES  255  wait-stretch clocks before a bus timeout (1..65535; used only with the macro)
// PORTS
//  pin_clk      in   1   master clock, rising edge
//  pin_rst      in   1   synchronous reset, active high
//  pin_run      in   1   1 = run microcycles; 0 = halt at the next microcycle boundary
//  pin_wreq     in   1   wait request (WI source), level, already synchronous to pin_clk
//  pin_c1..c4   out  1   clock phases 1..4, registered
//  pin_mcyc     out  1   one-clock pulse on the first clock of C1 of each microcycle
//  pin_wact     out  1   1 while the microcycle is stretched (S_WAIT)
//  pin_idle     out  1   1 while halted (S_IDLE)
//  pin_count    out  16  count of started microcycles, wraps 16'hFFFF -> 16'h0000
//  pin_berr     out  1   one-clock timeout pulse (macro only; tied 0 otherwise)
// BEHAVIOUR
//  - One clock. Reset is synchronous and active high. All outputs are registered.
//  - Reset values: c1..c4=0, mcyc=0, wact=0, idle=1, count=0, berr=0, state=S_IDLE.
//  - Reset mid-microcycle: at the sampling edge every phase drops to 0 and state goes to S_IDLE.
//    No phase is truncated to a glitch narrower than one clock.
//  - States: S_IDLE, S_PH1, S_GAP1, S_PH2, S_GAP2, S_WAIT, S_PH3, S_GAP3, S_PH4, S_GAP4.
//  - One 4-bit down-counter times each state. It loads PH_WIDTH-1 or GAP_WIDTH-1 on entry.
//  - S_PHn holds only Cn high. S_GAPn and S_WAIT hold all phases low.
//    At most one phase is high on any clock.
//  - GAP_WIDTH=0: S_PHn goes straight to the next phase state. Phases are then adjacent but never overlap.
//  - Microcycle length = 4*(PH_WIDTH+GAP_WIDTH) clocks plus wait clocks. The default is 12.
//  - S_IDLE -> S_PH1 on the clock after pin_run is sampled 1.
//    On that entry: mcyc=1 for one clock and count increments.
//  - S_GAP4 (or S_PH4 when GAP_WIDTH=0), at the last clock:
//    goes to S_PH1 if pin_run=1, else to S_IDLE.
//  - pin_run changes mid-microcycle have no effect until the boundary.
//  - Wait: pin_wreq is sampled on the last clock of S_GAP2 (of S_PH2 when GAP_WIDTH=0).
//    1 -> S_WAIT; 0 -> S_PH3.
//  - S_WAIT -> S_PH3 on the clock after pin_wreq is sampled 0. The wait can last indefinitely.
//  - pin_wreq is ignored in every other state.
//  - Simultaneous rst with any input: rst wins.
//  - Simultaneous run=0 with wreq=1: the wait completes first, then the halt at the boundary.
// CONFIGURATION
//  MCP_BUS_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to S_WAIT and counts every S_WAIT clock.
//   - When it reaches TMO_CYCLES: berr=1 for one clock and state forces to S_PH3, whatever pin_wreq is.
//   - The counter stays cleared outside S_WAIT.
//  MCP_BUS_TIMEOUT_EN undefined:
//   - No counter logic. pin_berr is a constant 0. S_WAIT is left only by pin_wreq=0.
// STRUCTURE
//  - Shared package mcp_pkg holds:
//    - the state encoding localparams (S_IDLE..S_GAP4, 4-bit)
//    - the phase index constants PH_C1..PH_C4
//    - the counter width constants (MCP_PH_CW=4, MCP_TMO_CW=16)
//  - One sub-module, mcp_wait_tmo: the timeout counter with its berr pulse.
//    Instanced only under MCP_BUS_TIMEOUT_EN.
//  - The FSM, phase timer and microcycle counter stay in mcp_phase_seq.
// TESTING (PH_WIDTH=2, GAP_WIDTH=1, TMO_CYCLES=16 unless noted)
//  1. rst=1 for 3 clks, then run=1, wreq=0.
//     -> C1 high 2 clks, low 1; then C2, C3, C4 the same.
//     -> mcyc pulses every 12 clks. count=5 after 60 clks from the first C1.
//  2. wreq=1 at the last S_GAP2 clk, held 7 clks.
//     -> all phases low, wact=1 for 7+1 clks. C3 rises on the clk after wreq falls.
//     -> That microcycle is 20 clks.
//  3. run dropped to 0 during C2.
//     -> C3 and C4 complete. idle=1 after the S_GAP4 clk. No further mcyc. count unchanged.
//  4. rst=1 while C3 is high.
//     -> C3=0 and idle=1 at the next edge, count=0.
//     -> run=1 then restarts cleanly at C1.
//  5. With MCP_BUS_TIMEOUT_EN, wreq held 1 forever.
//     -> berr pulses 1 clk after 16 wait clks. C3 follows. count keeps advancing.
//  6. GAP_WIDTH=0, count preset near wrap (run 65536 cycles, or force).
//     -> C1..C4 adjacent with no overlap; microcycle 8 clks; count wraps FFFF->0000.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared encodings for the MCP-1600 four-phase clock sequencer.
// States, phase indices and counter widths used by every mcp_* block.
package mcp_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_PH1  = 4'd1,
    S_GAP1 = 4'd2,
    S_PH2  = 4'd3,
    S_GAP2 = 4'd4,
    S_WAIT = 4'd5,
    S_PH3  = 4'd6,
    S_GAP3 = 4'd7,
    S_PH4  = 4'd8,
    S_GAP4 = 4'd9
  } state_e;

  localparam int PH_C1 = 0;
  localparam int PH_C2 = 1;
  localparam int PH_C3 = 2;
  localparam int PH_C4 = 3;

  localparam int MCP_PH_CW  = 4;
  localparam int MCP_TMO_CW = 16;

  function automatic logic is_phase(state_e s);
    return (s == S_PH1) || (s == S_PH2) ||
           (s == S_PH3) || (s == S_PH4);
  endfunction

endpackage

// File: rtl/mcp_wait_tmo.sv
// Bus timeout for the stretched microcycle: counts S_WAIT clocks.
// Built only when MCP_BUS_TIMEOUT_EN is defined.
module mcp_wait_tmo
  import mcp_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  output logic hit_o,
  output logic berr_o
);

  localparam logic [MCP_TMO_CW-1:0] TMO_LAST =
    MCP_TMO_CW'(TMO_CYCLES - 1);

  logic [MCP_TMO_CW-1:0] cnt_q, cnt_d;
  logic                  berr_q;

  assign hit_o  = wait_i && (cnt_q == TMO_LAST);
  assign berr_o = berr_q;

  // Leaving S_WAIT clears the count, so every wait starts from zero.
  always_comb begin
    cnt_d = '0;
    if (wait_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= hit_o;
    end
  end

endmodule

// File: rtl/mcp_phase_seq.sv
// MCP-1600 four-phase non-overlapping clock sequencer with wait stretch.
// Define MCP_BUS_TIMEOUT_EN to add the S_WAIT bus timeout (pin_berr).
module mcp_phase_seq
  import mcp_pkg::*;
#(
  parameter int PH_WIDTH   = 2,
  parameter int GAP_WIDTH  = 1,
  parameter int TMO_CYCLES = 255
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        pin_run,
  input  logic        pin_wreq,
  output logic        pin_c1,
  output logic        pin_c2,
  output logic        pin_c3,
  output logic        pin_c4,
  output logic        pin_mcyc,
  output logic        pin_wact,
  output logic        pin_idle,
  output logic [15:0] pin_count,
  output logic        pin_berr
);

  if (PH_WIDTH < 1 || PH_WIDTH > 15) begin : g_bad_ph
    $error("PH_WIDTH out of range 1..15");
  end
  if (GAP_WIDTH < 0 || GAP_WIDTH > 15) begin : g_bad_gap
    $error("GAP_WIDTH out of range 0..15");
  end
  if (TMO_CYCLES < 1 || TMO_CYCLES > 65535) begin : g_bad_tmo
    $error("TMO_CYCLES out of range 1..65535");
  end

  localparam bit NO_GAP = (GAP_WIDTH == 0);
  localparam logic [MCP_PH_CW-1:0] PH_LD =
    MCP_PH_CW'(PH_WIDTH - 1);
  localparam logic [MCP_PH_CW-1:0] GAP_LD =
    MCP_PH_CW'(NO_GAP ? 0 : GAP_WIDTH - 1);

  state_e               state_q, state_d;
  logic [MCP_PH_CW-1:0] tmr_q, tmr_d;
  logic [3:0]           phase_q, phase_d;
  logic                 mcyc_q, wact_q, idle_q;
  logic                 idle_d, wact_d;
  logic [15:0]          count_q, count_d;
  logic                 start;
  logic                 expire;
  logic                 tmo_hit;
  logic                 berr;

`ifdef MCP_BUS_TIMEOUT_EN
  mcp_wait_tmo #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk_i (pin_clk),
    .rst_i (pin_rst),
    .wait_i(state_q == S_WAIT),
    .hit_o (tmo_hit),
    .berr_o(berr)
  );
`else
  assign tmo_hit = 1'b0;
  assign berr    = 1'b0;
`endif

  assign expire = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pin_run) begin
          state_d = S_PH1;
          start   = 1'b1;
        end
      end
      S_PH1:
        if (expire) state_d = NO_GAP ? S_PH2 : S_GAP1;
      S_GAP1:
        if (expire) state_d = S_PH2;
      S_PH2: begin
        if (expire) begin
          if (!NO_GAP)       state_d = S_GAP2;
          else if (pin_wreq) state_d = S_WAIT;
          else               state_d = S_PH3;
        end
      end
      S_GAP2:
        if (expire) state_d = pin_wreq ? S_WAIT : S_PH3;
      S_WAIT:
        if (!pin_wreq || tmo_hit) state_d = S_PH3;
      S_PH3:
        if (expire) state_d = NO_GAP ? S_PH4 : S_GAP3;
      S_GAP3:
        if (expire) state_d = S_PH4;
      S_PH4, S_GAP4: begin
        // The microcycle boundary is the last timed state.
        if (expire) begin
          if (state_q == S_PH4 && !NO_GAP) begin
            state_d = S_GAP4;
          end else if (pin_run) begin
            state_d = S_PH1;
            start   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      tmr_d = is_phase(state_d) ? PH_LD : GAP_LD;
    else if (!expire)
      tmr_d = tmr_q - 1'b1;
  end

  always_comb begin
    phase_d        = '0;
    phase_d[PH_C1] = (state_d == S_PH1);
    phase_d[PH_C2] = (state_d == S_PH2);
    phase_d[PH_C3] = (state_d == S_PH3);
    phase_d[PH_C4] = (state_d == S_PH4);
    wact_d         = (state_d == S_WAIT);
    idle_d         = (state_d == S_IDLE);
    count_d        = count_q + {15'd0, start};
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      phase_q <= '0;
      mcyc_q  <= 1'b0;
      wact_q  <= 1'b0;
      idle_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      phase_q <= phase_d;
      mcyc_q  <= start;
      wact_q  <= wact_d;
      idle_q  <= idle_d;
      count_q <= count_d;
    end
  end

  assign pin_c1    = phase_q[PH_C1];
  assign pin_c2    = phase_q[PH_C2];
  assign pin_c3    = phase_q[PH_C3];
  assign pin_c4    = phase_q[PH_C4];
  assign pin_mcyc  = mcyc_q;
  assign pin_wact  = wact_q;
  assign pin_idle  = idle_q;
  assign pin_count = count_q;
  assign pin_berr  = berr;

endmodule

// File: tb/tb_mcp_phase_seq.sv
// Directed bench for mcp_phase_seq: default gap build plus a no-gap instance.
// Timeout sequence runs only when MCP_BUS_TIMEOUT_EN is defined.
module tb_mcp_phase_seq;

  typedef struct {
    logic        rst;
    logic        run;
    logic        wreq;
    logic [3:0]  c;
    logic        mcyc;
    logic        wact;
    logic        idle;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run, wreq, run1;
  logic c1, c2, c3, c4, mcyc, wact, idle, berr;
  logic [15:0] count;
  logic g1, g2, g3, g4, gmcyc, gwact, gidle, gberr;
  logic [15:0] gcount;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tv[63];

  mcp_phase_seq #(
    .PH_WIDTH(2), .GAP_WIDTH(1), .TMO_CYCLES(16)
  ) dut (
    .pin_clk(clk), .pin_rst(rst), .pin_run(run), .pin_wreq(wreq),
    .pin_c1(c1), .pin_c2(c2), .pin_c3(c3), .pin_c4(c4),
    .pin_mcyc(mcyc), .pin_wact(wact), .pin_idle(idle),
    .pin_count(count), .pin_berr(berr)
  );

  mcp_phase_seq #(
    .PH_WIDTH(2), .GAP_WIDTH(0), .TMO_CYCLES(16)
  ) dut_ng (
    .pin_clk(clk), .pin_rst(rst), .pin_run(run1), .pin_wreq(wreq),
    .pin_c1(g1), .pin_c2(g2), .pin_c3(g3), .pin_c4(g4),
    .pin_mcyc(gmcyc), .pin_wact(gwact), .pin_idle(gidle),
    .pin_count(gcount), .pin_berr(gberr)
  );

  function automatic logic [23:0] outs();
    return {c4, c3, c2, c1, mcyc, wact, idle, berr, count};
  endfunction

  function automatic logic [23:0] outs_ng();
    return {g4, g3, g2, g1, gmcyc, gwact, gidle, gberr, gcount};
  endfunction

  task automatic check(input string nm, input logic [23:0] got,
                       input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic w);
    @(negedge clk);
    run  = r;
    wreq = w;
    @(posedge clk);
    #1;
  endtask

  // {c4..c1, mcyc, wact, idle, berr, count} expected after one edge
  task automatic cyc(input logic r, input logic w, input logic [3:0] c,
                     input logic m, input logic wa, input logic id,
                     input logic b, input logic [15:0] cnt,
                     input string nm);
    step(r, w);
    check(nm, outs(), {c, m, wa, id, b, cnt});
  endtask

  initial begin
    rst  = 1'b1;
    run  = 1'b0;
    wreq = 1'b0;
    run1 = 1'b0;

    // 3 reset clocks then free run: 12-clock microcycle, 2 high / 1 low
    for (int i = 0; i < 3; i++) begin
      tv[i].rst = 1'b1; tv[i].run = 1'b0; tv[i].wreq = 1'b0;
      tv[i].c = 4'b0; tv[i].mcyc = 1'b0; tv[i].wact = 1'b0;
      tv[i].idle = 1'b1; tv[i].cnt = 16'd0;
    end
    for (int k = 0; k < 60; k++) begin
      int pos, ph;
      pos = k % 12;
      ph  = pos / 3;
      tv[3+k].rst  = 1'b0;
      tv[3+k].run  = 1'b1;
      tv[3+k].wreq = 1'b0;
      tv[3+k].c    = ((pos % 3) != 2) ? 4'(1 << ph) : 4'b0;
      tv[3+k].mcyc = (pos == 0);
      tv[3+k].wact = 1'b0;
      tv[3+k].idle = 1'b0;
      tv[3+k].cnt  = 16'(k / 12 + 1);
    end

    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      rst  = tv[i].rst;
      run  = tv[i].run;
      wreq = tv[i].wreq;
      @(posedge clk);
      #1;
      check($sformatf("t1_vec%0d", i), outs(),
            {tv[i].c, tv[i].mcyc, tv[i].wact, tv[i].idle,
             1'b0, tv[i].cnt});
    end

    // wreq high on last GAP2 clock plus 7 more: 8 wait clocks, 20-clock cycle
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 16'd6, "t2_ph1");
    cyc(1, 0, 4'd1, 0, 0, 0, 0, 16'd6, "t2_ph1b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd6, "t2_gap1");
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 16'd6, "t2_ph2");
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 16'd6, "t2_ph2b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd6, "t2_gap2");
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 4'd0, 0, 1, 0, 0, 16'd6, "t2_wait");
    cyc(1, 0, 4'd4, 0, 0, 0, 0, 16'd6, "t2_c3");
    cyc(1, 0, 4'd4, 0, 0, 0, 0, 16'd6, "t2_c3b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd6, "t2_gap3");
    cyc(1, 0, 4'd8, 0, 0, 0, 0, 16'd6, "t2_c4");
    cyc(1, 0, 4'd8, 0, 0, 0, 0, 16'd6, "t2_c4b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd6, "t2_gap4");
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 16'd7, "t2_next");

    // run drops during C2; wreq outside GAP2 is ignored
    cyc(1, 1, 4'd1, 0, 0, 0, 0, 16'd7, "t3_ph1b");
    cyc(1, 1, 4'd0, 0, 0, 0, 0, 16'd7, "t3_gap1");
    cyc(0, 1, 4'd2, 0, 0, 0, 0, 16'd7, "t3_ph2");
    cyc(0, 1, 4'd2, 0, 0, 0, 0, 16'd7, "t3_ph2b");
    cyc(0, 1, 4'd0, 0, 0, 0, 0, 16'd7, "t3_gap2");
    cyc(0, 0, 4'd4, 0, 0, 0, 0, 16'd7, "t3_c3");
    cyc(0, 0, 4'd4, 0, 0, 0, 0, 16'd7, "t3_c3b");
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 16'd7, "t3_gap3");
    cyc(0, 0, 4'd8, 0, 0, 0, 0, 16'd7, "t3_c4");
    cyc(0, 0, 4'd8, 0, 0, 0, 0, 16'd7, "t3_c4b");
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 16'd7, "t3_gap4");
    cyc(0, 0, 4'd0, 0, 0, 1, 0, 16'd7, "t3_idle");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 4'd0, 0, 0, 1, 0, 16'd7, "t3_hold");

    // halt requested together with a wait: wait finishes, then halt
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 16'd8, "t3b_start");
    cyc(0, 0, 4'd1, 0, 0, 0, 0, 16'd8, "t3b_ph1b");
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 16'd8, "t3b_gap1");
    cyc(0, 0, 4'd2, 0, 0, 0, 0, 16'd8, "t3b_ph2");
    cyc(0, 0, 4'd2, 0, 0, 0, 0, 16'd8, "t3b_ph2b");
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 16'd8, "t3b_gap2");
    cyc(0, 1, 4'd0, 0, 1, 0, 0, 16'd8, "t3b_wait");
    cyc(0, 1, 4'd0, 0, 1, 0, 0, 16'd8, "t3b_wait2");
    cyc(0, 0, 4'd4, 0, 0, 0, 0, 16'd8, "t3b_c3");
    cyc(0, 0, 4'd4, 0, 0, 0, 0, 16'd8, "t3b_c3b");
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 16'd8, "t3b_gap3");
    cyc(0, 0, 4'd8, 0, 0, 0, 0, 16'd8, "t3b_c4");
    cyc(0, 0, 4'd8, 0, 0, 0, 0, 16'd8, "t3b_c4b");
    cyc(0, 0, 4'd0, 0, 0, 0, 0, 16'd8, "t3b_gap4");
    cyc(0, 0, 4'd0, 0, 0, 1, 0, 16'd8, "t3b_idle");

    // reset while C3 is high, then clean restart
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 16'd9, "t4_start");
    cyc(1, 0, 4'd1, 0, 0, 0, 0, 16'd9, "t4_ph1b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd9, "t4_gap1");
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 16'd9, "t4_ph2");
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 16'd9, "t4_ph2b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd9, "t4_gap2");
    cyc(1, 0, 4'd4, 0, 0, 0, 0, 16'd9, "t4_c3");
    rst = 1'b1;
    cyc(1, 1, 4'd0, 0, 0, 1, 0, 16'd0, "t4_rst");
    rst = 1'b0;
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 16'd1, "t4_restart");
    cyc(1, 0, 4'd1, 0, 0, 0, 0, 16'd1, "t4_ph1b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd1, "t4_gap1");

    // no-gap instance: adjacent phases, 8-clock microcycle
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    check("t6_idle", outs_ng(), {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0});
    for (int k = 0; k < 24; k++) begin
      int pos;
      @(negedge clk);
      run1 = 1'b1;
      @(posedge clk);
      #1;
      pos = k % 8;
      check($sformatf("t6_ng%0d", k), outs_ng(),
            {4'(1 << (pos / 2)), pos == 0, 1'b0, 1'b0, 1'b0,
             16'(k / 8 + 1)});
    end
    run1 = 1'b0;

`ifdef MCP_BUS_TIMEOUT_EN
    // wreq stuck high: 16 wait clocks, berr with first C3 clock
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    cyc(1, 0, 4'd1, 1, 0, 0, 0, 16'd1, "t5_ph1");
    cyc(1, 0, 4'd1, 0, 0, 0, 0, 16'd1, "t5_ph1b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd1, "t5_gap1");
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 16'd1, "t5_ph2");
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 16'd1, "t5_ph2b");
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 16'd1, "t5_gap2");
    for (int i = 0; i < 16; i++)
      cyc(1, 1, 4'd0, 0, 1, 0, 0, 16'd1, "t5_wait");
    cyc(1, 1, 4'd4, 0, 0, 0, 1, 16'd1, "t5_berr");
    cyc(1, 1, 4'd4, 0, 0, 0, 0, 16'd1, "t5_c3b");
    cyc(1, 1, 4'd0, 0, 0, 0, 0, 16'd1, "t5_gap3");
    cyc(1, 1, 4'd8, 0, 0, 0, 0, 16'd1, "t5_c4");
    cyc(1, 1, 4'd8, 0, 0, 0, 0, 16'd1, "t5_c4b");
    cyc(1, 1, 4'd0, 0, 0, 0, 0, 16'd1, "t5_gap4");
    cyc(1, 1, 4'd1, 1, 0, 0, 0, 16'd2, "t5_next");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
